square_drawer: RTL and testbench

Consumer side of the square-location handshake. On a `go` request it erases the previously drawn square (if any), requests a new location from the location picker (`pick_start` / `pick_done`, `x_loc` / `y_loc`), then rasterises a SIDE×SIDE square at that location into the VGA framebuffer write port, one pixel per cycle. It also exports the current square position for game logic such as hit detection and scoring.

---
 rtl/square_drawer.sv | 101 ++++++++++
 tb/tb_square_drawer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/square_drawer.sv
// rtl/square_drawer.sv - erase/pick/draw sequencer that rasterises a SIDE x SIDE square into a framebuffer
module square_drawer #(
  parameter int SIDE  = 20,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic        pick_start,
  input  logic        pick_done,
  input  logic [10:0] x_loc,
  input  logic [10:0] y_loc,
  output logic [10:0] px_x,
  output logic [10:0] px_y,
  output logic        px_color,
  output logic        px_we,
  output logic        busy,
  output logic        done,
  output logic [10:0] sq_x,
  output logic [10:0] sq_y,
  output logic        sq_valid
);

  localparam int CW = (SIDE > 1) ? $clog2(SIDE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIDE - 1);
  localparam logic [10:0] XM = 11'(X_MAX);
  localparam logic [10:0] YM = 11'(Y_MAX);

  typedef enum logic [2:0] {IDLE, ERASE, REQ, WAIT, DRAW, FIN} state_t;

  state_t state, state_nx;
  logic [CW-1:0] row, col;
  logic [10:0] cur_x, cur_y;
  logic raster, last;

  assign raster     = (state == ERASE) || (state == DRAW);
  assign last       = (row == LAST) && (col == LAST);
  assign cur_x      = sq_x + 11'(col);
  assign cur_y      = sq_y + 11'(row);
  assign pick_start = (state == REQ);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (go) state_nx = sq_valid ? ERASE : REQ;
      ERASE: if (last) state_nx = REQ;
      REQ:   state_nx = WAIT;
      WAIT:  if (pick_done) state_nx = DRAW;
      DRAW:  if (last) state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      px_x     <= '0;
      px_y     <= '0;
      px_color <= 1'b0;
      px_we    <= 1'b0;
      sq_x     <= '0;
      sq_y     <= '0;
      sq_valid <= 1'b0;
    end else begin
      state <= state_nx;

      // Counters run identically whether or not a pixel is clipped.
      if (raster) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        row <= '0;
        col <= '0;
      end

      px_x     <= cur_x;
      px_y     <= cur_y;
      px_color <= (state == DRAW);
      px_we    <= raster && (cur_x < XM) && (cur_y < YM);

      if (state == WAIT && pick_done) begin
        sq_x <= x_loc;
        sq_y <= y_loc;
      end

      if (state == ERASE && last) sq_valid <= 1'b0;
      if (state == DRAW && last)  sq_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_square_drawer.sv
// tb/tb_square_drawer.sv - scoreboard bench for square_drawer with randomized picks and a behavioural model
module tb_square_drawer;

  localparam int SIDE  = 4;
  localparam int X_MAX = 640;
  localparam int Y_MAX = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        pick_done = 1'b0;
  logic [10:0] x_loc = '0;
  logic [10:0] y_loc = '0;
  logic        pick_start;
  logic [10:0] px_x, px_y, sq_x, sq_y;
  logic        px_color, px_we, busy, done, sq_valid;

  square_drawer #(.SIDE(SIDE), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk(clk), .reset(reset), .go(go),
    .pick_start(pick_start), .pick_done(pick_done),
    .x_loc(x_loc), .y_loc(y_loc),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_we(px_we),
    .busy(busy), .done(done),
    .sq_x(sq_x), .sq_y(sq_y), .sq_valid(sq_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int color; } pix_t;
  typedef struct { int x; int y; int d; } pick_t;
  typedef struct { int lat; int x; int y; } done_t;

  pix_t  px_q[$];
  pick_t pick_q[$];
  done_t done_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int go_cyc = 0;
  int done_seen = 0;
  int ps_count = 0;
  int draw_count = 0;
  int m_valid = 0;
  int m_x = 0;
  int m_y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every observed write and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    pix_t  ep;
    done_t ed;
    if (pick_start) ps_count++;
    if (px_we) begin
      if (px_color) draw_count++;
      if (px_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got (%0d,%0d,c%0d) expected none", px_x, px_y, px_color);
      end else begin
        ep = px_q.pop_front();
        check("px_x", 32'(px_x), ep.x);
        check("px_y", 32'(px_y), ep.y);
        check("px_color", 32'(px_color), ep.color);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        ed = done_q.pop_front();
        check("done_latency", cyc - go_cyc + 1, ed.lat);
        check("sq_x", 32'(sq_x), ed.x);
        check("sq_y", 32'(sq_y), ed.y);
        check("sq_valid", 32'(sq_valid), 1);
        check("px_queue_at_done", px_q.size(), 0);
      end
      done_seen = 1;
    end
  end

  // Location picker: answers 1+d cycles after it samples pick_start.
  initial begin
    pick_t p;
    forever begin
      @(negedge clk);
      if (pick_start && reset) begin
        if (pick_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pick_start: got 1 expected 0");
        end else begin
          p = pick_q.pop_front();
          repeat (1 + p.d) @(negedge clk);
          pick_done = 1'b1;
          x_loc = 11'(p.x);
          y_loc = 11'(p.y);
          @(negedge clk);
          pick_done = 1'b0;
        end
      end
    end
  end

  // Reference model: square erase/draw as a list of visible pixels in raster order.
  task automatic issue(input int x, input int y, input int d);
    int px, py;
    if (m_valid != 0) begin
      for (int r = 0; r < SIDE; r++)
        for (int c = 0; c < SIDE; c++) begin
          px = (m_x + c) % 2048;
          py = (m_y + r) % 2048;
          if (px < X_MAX && py < Y_MAX) px_q.push_back('{px, py, 0});
        end
    end
    for (int r = 0; r < SIDE; r++)
      for (int c = 0; c < SIDE; c++) begin
        px = (x + c) % 2048;
        py = (y + r) % 2048;
        if (px < X_MAX && py < Y_MAX) px_q.push_back('{px, py, 1});
      end
    done_q.push_back('{3 + SIDE * SIDE + ((m_valid != 0) ? SIDE * SIDE : 0) + d, x, y});
    pick_q.push_back('{x, y, d});
    m_valid = 1;
    m_x = x;
    m_y = y;
    done_seen = 0;
    ps_count = 0;
    draw_count = 0;
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc + 1;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", 32'(busy), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && done_seen == 0; i++) @(negedge clk);
    check("done_timeout", done_seen, 1);
    check("pick_start_pulses", ps_count, 1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {21'd0, pick_start, px_color, px_we, busy, done, sq_valid, 5'd0}, 0);
    check({tag, "_px_xy"}, {10'd0, px_x, px_y}, 0);
    check({tag, "_sq_xy"}, {10'd0, sq_x, sq_y}, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    issue(600, 400, 0);
    wait_done();
    issue(50, 50, 0);
    wait_done();
    issue(638, 478, 0);
    wait_done();

    // Stray pick_done in IDLE must not move the square.
    @(negedge clk);
    pick_done = 1'b1;
    x_loc = 11'd123;
    y_loc = 11'd321;
    @(negedge clk);
    pick_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_pick_sq_x", 32'(sq_x), 638);
    check("stray_pick_sq_y", 32'(sq_y), 478);
    check("stray_pick_busy", 32'(busy), 0);

    issue(100, 200, 5);
    wait_done();

    // go during DRAW is dropped, not queued.
    issue(10, 20, 0);
    for (int i = 0; i < 200 && draw_count < 3; i++) begin
      @(negedge clk);
      #1;
    end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    check("go_in_draw_ignored", 32'(busy), 0);
    check("no_extra_writes", px_q.size(), 0);

    for (int k = 0; k < 6; k++) begin
      issue($urandom_range(0, 660), $urandom_range(0, 500), $urandom_range(0, 5));
      wait_done();
    end

    // Reset after 7 draw pixels; next go must skip the erase.
    issue(300, 300, 0);
    for (int i = 0; i < 200 && draw_count < 7; i++) begin
      @(negedge clk);
      #1;
    end
    check("mid_draw_pixels", draw_count, 7);
    reset = 1'b0;
    px_q.delete();
    done_q.delete();
    pick_q.delete();
    m_valid = 0;
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b1;
    issue(200, 100, 0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
